gate_sweep_checker: RTL and testbench

Sequencer that exhaustively exercises two implementations of the same 2^N_IN-row Boolean function, such as a gate-level form and an expression form. It steps a shared stimulus vector through every minterm and waits a settle time. It then samples both implementation outputs, compares each against a parameterised truth table and accumulates per-implementation error counts plus the first failing minterm. It sits between a start/report interface and the combinational gate modules under check.

---
 rtl/gate_sweep_checker_pkg.sv | 19 +
 rtl/sweep_err_cnt.sv | 24 ++
 rtl/gate_sweep_checker.sv | 137 +++++++++++++
 tb/tb_gate_sweep_checker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_checker_pkg.sv
// Shared types and sizing helpers for the exhaustive two-implementation gate checker.
package gate_sweep_checker_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam int unsigned N_IN_DEF = 2;
  localparam int unsigned SETTLE_W = 4;

  // Number of truth-table rows for an n-input function.
  function automatic int unsigned minterms(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  // Error counters must hold every row failing, i.e. up to 2**n_in.
  function automatic int unsigned cnt_width(input int unsigned n_in);
    return n_in + 32'd1;
  endfunction

endpackage

// File: rtl/sweep_err_cnt.sv
// Per-implementation compare-and-count unit; one instance per implementation under check.
module sweep_err_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sample_en,
  input  logic         clear,
  input  logic         observed,
  input  logic         expected,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (sample_en && (observed != expected)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Steps a shared stimulus through every minterm, lets it settle, then scores both
// implementations against the expected truth table and records the first failing row.
module gate_sweep_checker
  import gate_sweep_checker_pkg::*;
#(
  parameter int unsigned             N_IN   = N_IN_DEF,
  parameter int unsigned             SETTLE = 1,
  parameter logic [2**N_IN-1:0]      EXPECT = 4'b0010
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic [N_IN-1:0]              stim,
  input  logic                         gate_a,
  input  logic                         gate_b,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [cnt_width(N_IN)-1:0]   err_a,
  output logic [cnt_width(N_IN)-1:0]   err_b,
  output logic [N_IN-1:0]              first_fail,
  output logic                         fail_valid
);

  localparam int unsigned M     = minterms(N_IN);
  localparam int unsigned CNT_W = cnt_width(N_IN);

  state_t                state_q, state_d;
  logic [N_IN-1:0]       stim_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic                  busy_d, done_d, pass_d, fail_valid_d;
  logic [N_IN-1:0]       first_fail_d;
  logic                  exp_bit_c, mis_a_c, mis_b_c, sample_en_c, clear_c;

  assign exp_bit_c = EXPECT[stim];
  assign mis_a_c   = (gate_a != exp_bit_c);
  assign mis_b_c   = (gate_b != exp_bit_c);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    stim_d       = stim;
    settle_d     = settle_q;
    busy_d       = busy;
    done_d       = done;
    pass_d       = pass;
    first_fail_d = first_fail;
    fail_valid_d = fail_valid;
    sample_en_c  = 1'b0;
    clear_c      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = APPLY;
          stim_d       = '0;
          settle_d     = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          first_fail_d = '0;
          fail_valid_d = 1'b0;
          clear_c      = 1'b1;
        end
      end
      APPLY: begin
        if (settle_q == SETTLE_W'(SETTLE - 1)) begin
          state_d  = SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      SAMPLE: begin
        sample_en_c = 1'b1;
        if ((mis_a_c || mis_b_c) && !fail_valid) begin
          first_fail_d = stim;
          fail_valid_d = 1'b1;
        end
        if (stim == N_IN'(M - 1)) begin
          // Counters are updated on this same edge, so fold in this row's result.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_a == '0) && !mis_a_c && (err_b == '0) && !mis_b_c;
        end else begin
          state_d = APPLY;
          stim_d  = stim + N_IN'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      stim       <= '0;
      settle_q   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      stim       <= stim_d;
      settle_q   <= settle_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      first_fail <= first_fail_d;
      fail_valid <= fail_valid_d;
    end
  end

  sweep_err_cnt #(.W(CNT_W)) u_cnt_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample_en (sample_en_c),
    .clear     (clear_c),
    .observed  (gate_a),
    .expected  (exp_bit_c),
    .count     (err_a)
  );

  sweep_err_cnt #(.W(CNT_W)) u_cnt_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample_en (sample_en_c),
    .clear     (clear_c),
    .observed  (gate_b),
    .expected  (exp_bit_c),
    .count     (err_b)
  );

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: two checker instances (settle 1 and 3) driven by selectable gate models.
module tb_gate_sweep_checker;

  localparam logic [3:0] EXP_TT = 4'b0010;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start0, start1;
  int         mode_a, mode_b;
  bit         sel;
  int         n_chk = 0;
  int         n_bad = 0;

  logic [1:0] stim0, stim1, ff0, ff1;
  logic       ga0, gb0, ga1, gb1;
  logic       busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
  logic [2:0] ea0, eb0, ea1, eb1;

  logic [1:0] stim_s, ff_s;
  logic       busy_s, done_s, pass_s, fv_s;
  logic [2:0] ea_s, eb_s;

  always #5 clk = ~clk;

  // Gate models: 0 correct a'.b, 1 XNOR, 2 stuck-at-1, 3 correct except minterm 2.
  function automatic logic gate_fn(input int mode, input logic [1:0] s);
    logic [3:0] tt;
    tt = EXP_TT;
    case (mode)
      0:       return tt[s];
      1:       return ~(s[1] ^ s[0]);
      2:       return 1'b1;
      default: return tt[s] ^ (s == 2'd2);
    endcase
  endfunction

  assign ga0 = gate_fn(mode_a, stim0);
  assign gb0 = gate_fn(mode_b, stim0);
  assign ga1 = gate_fn(mode_a, stim1);
  assign gb1 = gate_fn(mode_b, stim1);

  assign stim_s = sel ? stim1 : stim0;
  assign ff_s   = sel ? ff1   : ff0;
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;
  assign pass_s = sel ? pass1 : pass0;
  assign fv_s   = sel ? fv1   : fv0;
  assign ea_s   = sel ? ea1   : ea0;
  assign eb_s   = sel ? eb1   : eb0;

  gate_sweep_checker #(.N_IN(2), .SETTLE(1), .EXPECT(4'b0010)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .stim(stim0),
    .gate_a(ga0), .gate_b(gb0), .busy(busy0), .done(done0), .pass(pass0),
    .err_a(ea0), .err_b(eb0), .first_fail(ff0), .fail_valid(fv0)
  );

  gate_sweep_checker #(.N_IN(2), .SETTLE(3), .EXPECT(4'b0010)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .stim(stim1),
    .gate_a(ga1), .gate_b(gb1), .busy(busy1), .done(done1), .pass(pass1),
    .err_a(ea1), .err_b(eb1), .first_fail(ff1), .fail_valid(fv1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".stim"}, 32'(stim_s), 0);
    check_eq({tag, ".busy"}, 32'(busy_s), 0);
    check_eq({tag, ".done"}, 32'(done_s), 0);
    check_eq({tag, ".pass"}, 32'(pass_s), 0);
    check_eq({tag, ".err_a"}, 32'(ea_s), 0);
    check_eq({tag, ".err_b"}, 32'(eb_s), 0);
    check_eq({tag, ".first_fail"}, 32'(ff_s), 0);
    check_eq({tag, ".fail_valid"}, 32'(fv_s), 0);
  endtask

  task automatic check_results(input string tag, input int ea, input int eb,
                               input int ff, input int fv, input int ps);
    check_eq({tag, ".done"}, 32'(done_s), 1);
    check_eq({tag, ".busy"}, 32'(busy_s), 0);
    check_eq({tag, ".err_a"}, 32'(ea_s), 32'(ea));
    check_eq({tag, ".err_b"}, 32'(eb_s), 32'(eb));
    check_eq({tag, ".first_fail"}, 32'(ff_s), 32'(ff));
    check_eq({tag, ".fail_valid"}, 32'(fv_s), 32'(fv));
    check_eq({tag, ".pass"}, 32'(pass_s), 32'(ps));
  endtask

  // Accept a start, then follow the sweep cycle by cycle until done should rise.
  task automatic sweep(input string tag, input int settle, input bit hold);
    int n;
    n = 4 * (settle + 1);
    @(posedge clk); #1;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      start0 = 1'b0;
      start1 = 1'b0;
    end
    check_eq({tag, ".clr_err_a"}, 32'(ea_s), 0);
    check_eq({tag, ".clr_err_b"}, 32'(eb_s), 0);
    check_eq({tag, ".clr_fv"}, 32'(fv_s), 0);
    for (int i = 0; i < n; i++) begin
      check_eq({tag, ".stim"}, 32'(stim_s), 32'(i / (settle + 1)));
      check_eq({tag, ".busy_run"}, 32'(busy_s), 1);
      check_eq({tag, ".done_run"}, 32'(done_s), 0);
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    check_eq({tag, ".stim_end"}, 32'(stim_s), 3);
  endtask

  initial begin
    reset_n = 1'b0;
    start0  = 1'b0;
    start1  = 1'b0;
    mode_a  = 0;
    mode_b  = 0;
    sel     = 1'b0;
    #12;
    check_zero("reset0");
    sel = 1'b1;
    #1;
    check_zero("reset1");
    sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Both implementations correct.
    sweep("s1", 1, 1'b0);
    check_results("s1", 0, 0, 0, 0, 1);

    // B is XNOR: fails minterms 0, 1, 3.
    mode_b = 1;
    sweep("s2", 1, 1'b0);
    check_results("s2", 0, 3, 0, 1, 0);

    // A stuck-at-1: fails minterms 0, 2, 3.
    mode_a = 2;
    mode_b = 0;
    sweep("s3a", 1, 1'b0);
    check_results("s3a", 3, 0, 0, 1, 0);

    // Both wrong only at minterm 2.
    mode_a = 3;
    mode_b = 3;
    sweep("s3b", 1, 1'b0);
    check_results("s3b", 1, 1, 2, 1, 0);

    // Start held through the sweep: one sweep only, then DONE holds.
    mode_a = 2;
    mode_b = 0;
    sweep("s4", 1, 1'b1);
    check_results("s4", 3, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("s4.hold_done", 32'(done_s), 1);
      check_eq("s4.hold_stim", 32'(stim_s), 3);
    end
    mode_a = 0;
    sweep("s4r", 1, 1'b0);
    check_results("s4r", 0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a sweep.
    mode_a = 2;
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_eq("s5.pre_err_a", 32'(ea_s), 1);
    check_eq("s5.pre_busy", 32'(busy_s), 1);
    reset_n = 1'b0;
    #1;
    check_zero("s5.rst");
    @(negedge clk);
    reset_n = 1'b1;
    mode_a = 0;
    sweep("s5", 1, 1'b0);
    check_results("s5", 0, 0, 0, 0, 1);

    // Settle of 3 cycles, same gates as the XNOR case.
    sel    = 1'b1;
    mode_a = 0;
    mode_b = 1;
    sweep("s6", 3, 1'b0);
    check_results("s6", 0, 3, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
